// File: rtl/axi_ll_tx_credit_fifo.sv
// Credit-gated transmit FIFO for one logic-link channel: buffers packed words and
// launches them toward the link while far-end credit exists. Stats via AXI_LL_TX_STATS_EN.
module axi_ll_tx_credit_fifo #(
    parameter int unsigned WIDTH        = 47,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned INIT_CREDITS = 8
) (
    input  logic                            clk_wr,
    input  logic                            rst_wr,
    input  logic                            user_vld,
    input  logic [WIDTH-1:0]                txfifo_data,
    output logic                            user_ready,
    input  logic                            tx_online,
    input  logic                            rx_credit_return,
    output logic                            tx_push,
    output logic [WIDTH-1:0]                tx_data,
    output logic [$clog2(DEPTH):0]          fifo_count,
    output logic [$clog2(INIT_CREDITS):0]   credit_count,
    output logic                            credit_err
`ifdef AXI_LL_TX_STATS_EN
    ,
    output logic [31:0]                     tx_word_cnt,
    output logic [15:0]                     stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned CRD_W = $clog2(INIT_CREDITS) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CRD_W-1:0] crd_q, crd_d;
    logic             tx_push_q, tx_push_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             err_q, err_d;
    logic             push_c, launch_c;
`ifdef AXI_LL_TX_STATS_EN
    logic [31:0]      word_cnt_q, word_cnt_d;
    logic [15:0]      stall_q, stall_d;
`endif

    // Handshake, launch decision and next-state for pointers, counters and outputs
    always_comb begin
        user_ready = tx_online && (cnt_q != CNT_W'(DEPTH));
        push_c     = user_vld && user_ready;
        launch_c   = tx_online && (cnt_q != '0) && (crd_q != '0);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        crd_d      = crd_q;
        err_d      = err_q;
        tx_push_d  = launch_c;
        tx_data_d  = tx_data_q;

        if (push_c) wptr_d = wptr_q + PTR_W'(1);
        if (launch_c) begin
            rptr_d    = rptr_q + PTR_W'(1);
            tx_data_d = mem_q[rptr_q];
        end

        case ({push_c, launch_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // A return at full credit with no launch is a far-end protocol error
        case ({rx_credit_return, launch_c})
            2'b01:   crd_d = crd_q - CRD_W'(1);
            2'b10: begin
                if (crd_q == CRD_W'(INIT_CREDITS)) err_d = 1'b1;
                else                               crd_d = crd_q + CRD_W'(1);
            end
            default: crd_d = crd_q;
        endcase
    end

`ifdef AXI_LL_TX_STATS_EN
    always_comb begin
        word_cnt_d = tx_push_q ? (word_cnt_q + 32'd1) : word_cnt_q;
        stall_d    = stall_q;
        if (tx_online && (cnt_q != '0) && (crd_q == '0) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            word_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign tx_word_cnt = word_cnt_q;
    assign stall_cnt   = stall_q;
`endif

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            crd_q     <= CRD_W'(INIT_CREDITS);
            err_q     <= 1'b0;
            tx_push_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            crd_q     <= crd_d;
            err_q     <= err_d;
            tx_push_q <= tx_push_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage array carries no reset; occupancy alone defines valid entries
    always_ff @(posedge clk_wr) begin
        if (!rst_wr && push_c) mem_q[wptr_q] <= txfifo_data;
    end

    assign tx_push      = tx_push_q;
    assign tx_data      = tx_data_q;
    assign fifo_count   = cnt_q;
    assign credit_count = crd_q;
    assign credit_err   = err_q;

endmodule

// File: tb/tb_axi_ll_tx_credit_fifo.sv
// Randomized and directed bench for axi_ll_tx_credit_fifo against a queue-based model.
module tb_axi_ll_tx_credit_fifo;

    localparam int unsigned W   = 47;
    localparam int unsigned D   = 16;
    localparam int unsigned CR  = 8;

    logic          clk_wr = 1'b0;
    logic          rst_wr = 1'b1;
    logic          user_vld = 1'b0;
    logic [W-1:0]  txfifo_data = '0;
    logic          user_ready;
    logic          tx_online = 1'b0;
    logic          rx_credit_return = 1'b0;
    logic          tx_push;
    logic [W-1:0]  tx_data;
    logic [4:0]    fifo_count;
    logic [3:0]    credit_count;
    logic          credit_err;
`ifdef AXI_LL_TX_STATS_EN
    logic [31:0]   tx_word_cnt;
    logic [15:0]   stall_cnt;
`endif

    axi_ll_tx_credit_fifo #(.WIDTH(W), .DEPTH(D), .INIT_CREDITS(CR)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .user_vld(user_vld), .txfifo_data(txfifo_data),
        .user_ready(user_ready), .tx_online(tx_online), .rx_credit_return(rx_credit_return),
        .tx_push(tx_push), .tx_data(tx_data), .fifo_count(fifo_count),
        .credit_count(credit_count), .credit_err(credit_err)
`ifdef AXI_LL_TX_STATS_EN
        , .tx_word_cnt(tx_word_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk_wr = ~clk_wr;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO as a queue, credits as an integer
    logic [W-1:0] q_m[$];
    int           credit_m = CR;
    logic         err_m    = 1'b0;
    logic         push_m   = 1'b0;
    logic [W-1:0] data_m   = '0;
    logic         ready_m  = 1'b0;
    logic         obs_ready;
    int           words_m  = 0;
    int           stall_m  = 0;

    // One clock of stimulus: drive at negedge, advance model, return #1 after posedge
    task automatic step(input logic rst, input logic vld, input logic [W-1:0] d,
                        input logic on, input logic ret);
        logic do_push, do_launch, do_stall;
        @(negedge clk_wr);
        rst_wr = rst; user_vld = vld; txfifo_data = d; tx_online = on; rx_credit_return = ret;
        #1;
        obs_ready = user_ready;
        ready_m   = on && (q_m.size() != D);
        do_push   = vld && ready_m;
        do_launch = on && (q_m.size() != 0) && (credit_m != 0);
        do_stall  = on && (q_m.size() != 0) && (credit_m == 0);
        if (rst) begin
            q_m.delete(); credit_m = CR; err_m = 1'b0; push_m = 1'b0; data_m = '0;
            words_m = 0; stall_m = 0;
        end else begin
            if (push_m) words_m++;
            if (do_stall && stall_m != 65535) stall_m++;
            push_m = do_launch;
            if (do_launch) data_m = q_m.pop_front();
            if (do_push) q_m.push_back(d);
            if (do_launch && !ret) credit_m--;
            else if (ret && !do_launch) begin
                if (credit_m == CR) err_m = 1'b1;
                else credit_m++;
            end
        end
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        total++; if (tx_push !== 1'b0) begin bad++; $display("FAIL reset_push got %0b want 0", tx_push); end
        total++; if (tx_data !== '0) begin bad++; $display("FAIL reset_data got %0h want 0", tx_data); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        total++; if (credit_count !== 4'd8) begin bad++; $display("FAIL reset_credit got %0d want 8", credit_count); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_err got %0b want 0", credit_err); end
        total++; if (user_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %0b want 0", user_ready); end
`ifdef AXI_LL_TX_STATS_EN
        total++; if (tx_word_cnt !== 32'd0 || stall_cnt !== 16'd0) begin bad++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", tx_word_cnt, stall_cnt); end
`endif
    endtask

    task automatic test_latency();
        step(1'b0, 1'b1, W'(48'h1234), 1'b1, 1'b0);
        total++; if (tx_push !== 1'b0) begin bad++; $display("FAIL lat_early got %0b want 0", tx_push); end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (tx_push !== 1'b1 || tx_data !== W'(48'h1234)) begin bad++;
            $display("FAIL lat_push got %0b/%0h want 1/1234", tx_push, tx_data); end
        total++; if (credit_count !== 4'd7 || fifo_count !== 5'd0) begin bad++;
            $display("FAIL lat_counts got crd=%0d cnt=%0d want 7/0", credit_count, fifo_count); end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (tx_push !== 1'b0 || tx_data !== W'(48'h1234)) begin bad++;
            $display("FAIL lat_hold got %0b/%0h want 0/1234", tx_push, tx_data); end
    endtask

    task automatic test_credit_exhaust();
        int n;
        n = 0;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, i < 12, rnd_word(), 1'b1, 1'b0);
            if (tx_push) n++;
            total++; if (tx_push !== push_m || tx_data !== data_m) begin bad++;
                $display("FAIL exh_word step %0d got %0b/%0h want %0b/%0h", i, tx_push, tx_data, push_m, data_m); end
        end
        total++; if (n != 8) begin bad++; $display("FAIL exh_launches got %0d want 8", n); end
        total++; if (credit_count !== 4'd0 || fifo_count !== 5'd4 || user_ready !== 1'b1) begin bad++;
            $display("FAIL exh_state got crd=%0d cnt=%0d rdy=%0b want 0/4/1", credit_count, fifo_count, user_ready); end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, i < 2);
            if (tx_push) n++;
            total++; if (tx_push !== push_m || tx_data !== data_m) begin bad++;
                $display("FAIL exh_ret step %0d got %0b/%0h want %0b/%0h", i, tx_push, tx_data, push_m, data_m); end
        end
        total++; if (n != 2 || fifo_count !== 5'd2) begin bad++;
            $display("FAIL exh_ret_cnt got %0d launches cnt=%0d want 2/2", n, fifo_count); end
    endtask

    task automatic test_full();
        int n;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, i < 8, rnd_word(), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b0);
        total++; if (fifo_count !== 5'd16 || user_ready !== 1'b0) begin bad++;
            $display("FAIL full_state got cnt=%0d rdy=%0b want 16/0", fifo_count, user_ready); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, W'(48'hDEAD), 1'b1, 1'b0);
            total++; if (obs_ready !== 1'b0 || fifo_count !== 5'd16) begin bad++;
                $display("FAIL full_17th got rdy=%0b cnt=%0d want 0/16", obs_ready, fifo_count); end
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, i < 17);
            if (tx_push) n++;
            total++; if (tx_push !== push_m || tx_data !== data_m) begin bad++;
                $display("FAIL full_drain step %0d got %0b/%0h want %0b/%0h", i, tx_push, tx_data, push_m, data_m); end
        end
        total++; if (n != 16 || fifo_count !== 5'd0 || credit_err !== 1'b0) begin bad++;
            $display("FAIL full_delivered got %0d cnt=%0d err=%0b want 16/0/0", n, fifo_count, credit_err); end
    endtask

    task automatic test_credit_collision();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b0);
        total++; if (credit_count !== 4'd5) begin bad++; $display("FAIL coll_pre got %0d want 5", credit_count); end
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        total++; if (credit_count !== 4'd5 || tx_push !== 1'b1) begin bad++;
            $display("FAIL coll_same got crd=%0d push=%0b want 5/1", credit_count, tx_push); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        total++; if (credit_count !== 4'd8 || credit_err !== 1'b0) begin bad++;
            $display("FAIL coll_refill got crd=%0d err=%0b want 8/0", credit_count, credit_err); end
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        total++; if (credit_count !== 4'd8 || credit_err !== 1'b1) begin bad++;
            $display("FAIL coll_sat got crd=%0d err=%0b want 8/1", credit_count, credit_err); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b0);
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL coll_sticky got %0b want 1", credit_err); end
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL coll_clr got %0b want 0", credit_err); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, i < 8 || i >= 11, rnd_word(), 1'b1, 1'b0);
        total++; if (fifo_count !== 5'd6 || credit_count !== 4'd0) begin bad++;
            $display("FAIL rmid_pre got cnt=%0d crd=%0d want 6/0", fifo_count, credit_count); end
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        total++; if (fifo_count !== 5'd0 || credit_count !== 4'd8 || tx_push !== 1'b0) begin bad++;
            $display("FAIL rmid_post got cnt=%0d crd=%0d push=%0b want 0/8/0", fifo_count, credit_count, tx_push); end
        step(1'b0, 1'b1, W'(48'hABCD), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (tx_push !== 1'b1 || tx_data !== W'(48'hABCD)) begin bad++;
            $display("FAIL rmid_first got %0b/%0h want 1/abcd", tx_push, tx_data); end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 97) == 0, ($urandom % 4) != 0, rnd_word(),
                 (i % 100) < 70 ? (($urandom % 8) != 0) : (($urandom % 3) == 0),
                 ($urandom % 3) == 0);
            total++; if (obs_ready !== ready_m) begin bad++;
                $display("FAIL rnd_ready step %0d got %0b want %0b", i, obs_ready, ready_m); end
            total++; if (tx_push !== push_m || tx_data !== data_m) begin bad++;
                $display("FAIL rnd_out step %0d got %0b/%0h want %0b/%0h", i, tx_push, tx_data, push_m, data_m); end
            total++; if (fifo_count !== 5'(q_m.size()) || credit_count !== 4'(credit_m) || credit_err !== err_m) begin bad++;
                $display("FAIL rnd_state step %0d got %0d/%0d/%0b want %0d/%0d/%0b", i, fifo_count,
                         credit_count, credit_err, q_m.size(), credit_m, err_m); end
`ifdef AXI_LL_TX_STATS_EN
            total++; if (tx_word_cnt !== 32'(words_m) || stall_cnt !== 16'(stall_m)) begin bad++;
                $display("FAIL rnd_stats step %0d got %0d/%0d want %0d/%0d", i, tx_word_cnt, stall_cnt, words_m, stall_m); end
`endif
        end
    endtask

`ifdef AXI_LL_TX_STATS_EN
    task automatic test_stats();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (tx_word_cnt !== 32'd20 || stall_cnt !== 16'd3) begin bad++;
            $display("FAIL stats_dir got %0d/%0d want 20/3", tx_word_cnt, stall_cnt); end
        total++; if (tx_word_cnt !== 32'(words_m) || stall_cnt !== 16'(stall_m)) begin bad++;
            $display("FAIL stats_model got %0d/%0d want %0d/%0d", tx_word_cnt, stall_cnt, words_m, stall_m); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_credit_exhaust();
        test_full();
        test_credit_collision();
        test_reset_mid();
`ifdef AXI_LL_TX_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_ll_tx_credit_fifo.md
Name: axi_ll_tx_credit_fifo

Overview:
- Logic-link transmit stage placed directly downstream of the AXI-MM master/slave packing block.
- Accepts one packed channel word per handshake on the user_*_vld / txfifo_*_data / user_*_ready interface and buffers it in a FIFO.
- Launches words toward the AIB link only while the far-end receive FIFO has credit.
- One instance per transmit channel (AR, AW, W on the master side).

Parameters:
- WIDTH, 47, packed channel word width (47 for AR/AW, 39 for W).
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- INIT_CREDITS, 8, credits loaded at reset; equals far-end RX FIFO depth; minimum 1.

Ports:
- clk_wr  in  1  single clock for the whole block.
- rst_wr  in  1  synchronous, active-high reset.
- user_vld  in  1  upstream word valid.
- txfifo_data  in  WIDTH  upstream packed word.
- user_ready  out  1  upstream may transfer.
- tx_online  in  1  link trained; gates push and launch.
- rx_credit_return  in  1  one-cycle pulse = one credit returned by far end.
- tx_push  out  1  registered strobe; tx_data valid this cycle.
- tx_data  out  WIDTH  registered word to link.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- credit_count  out  $clog2(INIT_CREDITS)+1  credits available.
- credit_err  out  1  sticky: credit returned while credit_count == INIT_CREDITS.

Behaviour:
- Reset values:
  - tx_push = 0, tx_data = 0, fifo_count = 0, credit_count = INIT_CREDITS, credit_err = 0.
  - Write/read pointers = 0.
  - user_ready = 0, because tx_online is gated into it.
- user_ready = tx_online && (fifo_count != DEPTH). Combinational; does not depend on user_vld.
- Push: user_vld && user_ready writes txfifo_data at wptr; wptr increments modulo DEPTH.
- Launch condition: tx_online && fifo_count != 0 && credit_count != 0.
  - Same cycle: read entry at rptr, rptr increments.
  - Next cycle: tx_push = 1 and tx_data = that word.
  - Otherwise tx_push = 0 and tx_data holds its last value.
- Latency: a word pushed in cycle N into an empty FIFO with credit produces tx_push in cycle N+2 (written N, launched N+1, visible on the registered output N+2). Empty FIFO: no bypass path.
- Throughput: one launch per cycle while credit and data are available.
- fifo_count: +1 on push only, -1 on launch only, unchanged when both occur in the same cycle.
- Full boundary: when full, user_ready = 0. A same-cycle launch does not re-open user_ready in that cycle.
- credit_count: -1 on launch, +1 on rx_credit_return, unchanged when both occur together.
- Credit saturation: a return with credit_count == INIT_CREDITS and no same-cycle launch leaves the count unchanged and sets credit_err. credit_err clears only on rst_wr.
- Zero credit: no launch; data stays buffered; user_ready stays governed by fullness only.
- tx_online deassert mid-stream:
  - Push and launch stop the next evaluated cycle; an already registered tx_push still completes.
  - FIFO contents and credits are retained.
  - Launching resumes when tx_online reasserts.
- rst_wr mid-operation: all contents discarded; pointers, counters and outputs return to reset values in the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty come from fifo_count, not pointer compare.

Optional Feature:
- Macro: AXI_LL_TX_STATS_EN.
- Defined:
  - Adds output tx_word_cnt [31:0], reset 0, incremented on each tx_push cycle, wraps 0xFFFF_FFFF -> 0.
  - Adds output stall_cnt [15:0], incremented each cycle with fifo_count != 0 && credit_count == 0 && tx_online; saturates at 0xFFFF.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then tx_online=1, push 0x1234 with 8 credits -> tx_push at push+2 cycles, tx_data=0x1234, credit_count=7, fifo_count returns 0.
- Never return credits, push 12 words -> exactly 8 tx_push, credit_count=0, fifo_count=4, user_ready=1; then return 2 pulses -> 2 more launches, in order.
- Credits held at 0, push 16 words -> fifo_count=16, user_ready=0; 17th user_vld held -> not accepted; restore credits -> all 16 words delivered in order, no loss or duplication.
- At 5 credits, launch and rx_credit_return in the same cycle -> credit_count stays 5; at 8 credits, idle return pulse -> credit_count=8, credit_err=1, stays 1 until rst_wr.
- 6 words buffered, assert rst_wr one cycle -> next cycle fifo_count=0, credit_count=8, tx_push=0; a subsequent push of 0xABCD is delivered first.
- With AXI_LL_TX_STATS_EN, 20 launches plus 3 zero-credit stall cycles -> tx_word_cnt=20, stall_cnt=3.
